mul_digit_seq_ctrl: RTL and testbench

- Sequencer that computes one WIDTH x WIDTH unsigned product by time-multiplexing a single small DIGIT x DIGIT multiplier core, such as the 2x2 generated cores.
- Walks every digit pair, drives the core's operands, and shift-accumulates the returned partial products.
- Exposes valid/ready handshakes on both input and output.
- Sits between the operand source and the small combinational core. The core is external, so any generated core variant can be plugged in and scored.

---
 rtl/mul_digit_seq_ctrl.sv | 118 +++++++++++
 tb/tb_mul_digit_seq_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_digit_seq_ctrl.sv
// Digit-serial WIDTH x WIDTH multiplier sequencer driving an external DIGIT x DIGIT core.
// Optional core self-check enabled by defining MUL_SEQ_SELF_CHECK_EN.
module mul_digit_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic [DIGIT-1:0]     core_a,
    output logic [DIGIT-1:0]     core_b,
    input  logic [2*DIGIT-1:0]   core_p,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p_out,
    output logic                 busy,
    output logic                 err
);

    localparam int ND = WIDTH / DIGIT;
    localparam int IW = (ND > 1) ? $clog2(ND) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_nx;
    logic [WIDTH-1:0]     a_reg, b_reg;
    logic [IW-1:0]        i_idx, j_idx;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   pp_ext, pp_shift;
    logic                 accept, last_i, last_pair;
    int unsigned          shamt;

    assign accept    = (state == IDLE) && in_valid;
    assign last_i    = (i_idx == IW'(ND - 1));
    assign last_pair = last_i && (j_idx == IW'(ND - 1));

    // NOTE: sequential state uses non-blocking assignments and an asynchronous reset
    // in the sensitivity list, so reset takes effect without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (last_pair) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign out_valid = (state == DONE);
    assign p_out     = acc;

    // Core operands come only from registered operands and indices; zero outside RUN.
    always_comb begin
        core_a = '0;
        core_b = '0;
        if (busy) begin
            core_a = a_reg[DIGIT*i_idx +: DIGIT];
            core_b = b_reg[DIGIT*j_idx +: DIGIT];
        end
    end

    always_comb begin
        pp_ext                = '0;
        pp_ext[2*DIGIT-1:0]   = core_p;
        shamt                 = DIGIT * (int'(i_idx) + int'(j_idx));
        pp_shift              = pp_ext << shamt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            i_idx <= '0;
            j_idx <= '0;
        end else if (accept) begin
            a_reg <= a_in;
            b_reg <= b_in;
            acc   <= '0;
            i_idx <= '0;
            j_idx <= '0;
        end else if (busy) begin
            acc <= acc + pp_shift;
            if (last_i) begin
                i_idx <= '0;
                j_idx <= last_pair ? '0 : j_idx + 1'b1;
            end else begin
                i_idx <= i_idx + 1'b1;
            end
        end
    end

`ifdef MUL_SEQ_SELF_CHECK_EN
    logic [2*DIGIT-1:0] ref_p;
    assign ref_p = core_a * core_b;

    // Sticky until the next accepted operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         err <= 1'b0;
        else if (accept)                 err <= 1'b0;
        else if (busy && core_p != ref_p) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mul_digit_seq_ctrl.sv
// Self-checking bench for mul_digit_seq_ctrl: vector table, hand-written corner
// sequences and randomized operands against an arithmetic digit-product model.
module tb_mul_digit_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int DIGIT = 2;
    localparam int ND    = WIDTH / DIGIT;
    localparam int NP    = ND * ND;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a_in, b_in;
    logic [DIGIT-1:0]   core_a, core_b;
    logic [2*DIGIT-1:0] core_p;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] p_out;
    logic               busy;
    logic               err;
    logic               fault_en;

    int n_total  = 0;
    int n_passed = 0;

    mul_digit_seq_ctrl #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in),
        .core_a(core_a), .core_b(core_b), .core_p(core_p),
        .out_valid(out_valid), .out_ready(out_ready),
        .p_out(p_out), .busy(busy), .err(err)
    );

    // External core: ideal product, or zero for the 3x3 digit pair when faulted.
    assign core_p = (fault_en && core_a == 2'd3 && core_b == 2'd3) ? 4'd0 : core_a * core_b;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        else
            n_passed++;
    endtask

    function automatic logic [3:0] core_fn(input logic [1:0] da, input logic [1:0] db, input bit fault);
        if (fault && da == 2'd3 && db == 2'd3) return 4'd0;
        return 4'(da * db);
    endfunction

    // Product as the sum of digit products weighted by their positions.
    function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                  input bit fault);
        logic [2*WIDTH-1:0] sum = '0;
        for (int j = 0; j < ND; j++)
            for (int i = 0; i < ND; i++)
                sum += (2*WIDTH)'(core_fn(a[DIGIT*i +: DIGIT], b[DIGIT*j +: DIGIT], fault)) << (DIGIT*(i+j));
        return sum;
    endfunction

    function automatic bit pair_faulty(input logic [1:0] da, input logic [1:0] db, input bit fault);
`ifdef MUL_SEQ_SELF_CHECK_EN
        return fault && (core_fn(da, db, fault) != 4'(da * db));
`else
        return 1'b0;
`endif
    endfunction

    // Full operation: accept, NP RUN cycles with operand sequencing checks,
    // optional DONE stall with a rejected new offer, then the output handshake.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int hold,
                          input bit fault, input logic [2*WIDTH-1:0] exp_p);
        int  waited = 0;
        bit  err_exp = 1'b0;
        logic [1:0] da, db;
        fault_en = fault;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
        in_valid  = 1'b1;
        a_in      = a;
        b_in      = b;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 0; k < NP; k++) begin
            @(negedge clk);
            da = a[DIGIT*(k % ND) +: DIGIT];
            db = b[DIGIT*(k / ND) +: DIGIT];
            check("run_busy", busy, 1);
            check("run_in_ready", in_ready, 0);
            check("run_out_valid", out_valid, 0);
            check("run_core_a", core_a, da);
            check("run_core_b", core_b, db);
            check("run_err", err, err_exp);
            if (pair_faulty(da, db, fault)) err_exp = 1'b1;
            if (k == 5) begin
                in_valid = 1'b1;   // ignored while running
                a_in = ~a;
            end
            if (k == 6) in_valid = 1'b0;
        end
        @(negedge clk);
        check("done_out_valid", out_valid, 1);
        check("done_p_out", p_out, exp_p);
        check("done_err", err, err_exp);
        check("done_busy", busy, 0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a_in     = 8'h01;
            b_in     = 8'h01;
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_p_out", p_out, exp_p);
            check("hold_in_ready", in_ready, 0);
            check("hold_core_a", core_a, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("post_out_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_p_out_kept", p_out, exp_p);
        check("post_err", err, err_exp);
    endtask

    typedef struct {
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        int                 hold;
        bit                 fault;
        logic [2*WIDTH-1:0] p;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{a: 8'hFF, b: 8'hFF, hold: 0, fault: 1'b0, p: 16'hFE01};
        vecs[1] = '{a: 8'h00, b: 8'hA5, hold: 0, fault: 1'b0, p: 16'h0000};
        vecs[2] = '{a: 8'h1B, b: 8'h2D, hold: 5, fault: 1'b0, p: 16'h04BF};
        vecs[3] = '{a: 8'hE4, b: 8'h1B, hold: 0, fault: 1'b0, p: 16'h180C};
        vecs[4] = '{a: 8'hFF, b: 8'hFF, hold: 0, fault: 1'b1, p: 16'h0000};
        vecs[5] = '{a: 8'h02, b: 8'h02, hold: 0, fault: 1'b0, p: 16'h0004};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; fault_en = 1'b0;
        a_in = '0; b_in = '0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_p_out", p_out, 0);
        check("rst_err", err, 0);
        check("rst_core_a", core_a, 0);
        check("rst_core_b", core_b, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Latency: out_valid low through NP RUN cycles, high after the NP-th edge past accept.
        @(negedge clk);
        in_valid = 1'b1; a_in = 8'hFF; b_in = 8'hFF; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (NP - 1) @(posedge clk);
        #1;
        check("lat_before", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_at", out_valid, 1);
        check("lat_p_out", p_out, 16'hFE01);
        @(posedge clk);
        #1;
        check("lat_in_ready", in_ready, 1);
        out_ready = 1'b0;

        for (int v = 0; v < 6; v++)
            run_op(vecs[v].a, vecs[v].b, vecs[v].hold, vecs[v].fault, vecs[v].p);
        fault_en = 1'b0;

        // Reset mid-operation at RUN cycle 7.
        @(negedge clk);
        in_valid = 1'b1; a_in = 8'h55; b_in = 8'h55;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_p_out", p_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_core_a", core_a, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(8'h03, 8'h03, 0, 1'b0, 16'h0009);

        for (int r = 0; r < 20; r++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            run_op(ra, rb, $urandom_range(0, 2), 1'b0, model(ra, rb, 1'b0));
        end
        run_op(8'hF3, 8'h3F, 1, 1'b1, model(8'hF3, 8'h3F, 1'b1));

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
